// File: rtl/mem_bus_pkg.sv
// Shared encodings for the MEM-stage data-bus master and its lane generator.
// Optional build macro used by consumers of this package: MEM_BUS_TIMEOUT_EN.
package mem_bus_pkg;

  // Access size encodings on the op input
  localparam logic [1:0] OP_WORD = 2'b00;
  localparam logic [1:0] OP_HALF = 2'b01;
  localparam logic [1:0] OP_BYTE = 2'b10;
  localparam logic [1:0] OP_NONE = 2'b11;

  // REQ cycles without ack before a fault is declared (timeout build only)
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_DONE  = 2'b10,
    ST_FAULT = 2'b11
  } mem_state_e;

endpackage

// File: rtl/mem_lane_gen.sv
// Byte-enable, store-lane replication and alignment decode for a 32-bit bus.
// Purely combinational so it can be shared with an instruction-side master.
module mem_lane_gen
  import mem_bus_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic        aligned
);

  // Decode enables and lane placement from size and low address bits
  always_comb begin
    be         = 4'b0000;
    lane_wdata = wdata;
    aligned    = 1'b0;
    case (op)
      OP_WORD: begin
        be         = 4'b1111;
        lane_wdata = wdata;
        aligned    = (addr_lo == 2'b00);
      end
      OP_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
        aligned    = ~addr_lo[0];
      end
      OP_BYTE: begin
        be         = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        aligned    = 1'b1;
      end
      default: begin
        be         = 4'b0000;
        lane_wdata = wdata;
        aligned    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage data-bus master: runs one req/ack transfer per load/store,
// stalls the pipeline while it is in flight and captures the read word.
// Build macro: MEM_BUS_TIMEOUT_EN adds a REQ-state timeout that ends in FAULT.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for an access; aligned access is registered onto the bus
// ST_REQ   | bus_req high, bus fields frozen until bus_ack (or timeout)
// ST_DONE  | transfer finished, one release cycle with stall low
// ST_FAULT | bus error or timeout, one cycle with bus_fault high
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic [1:0]  rdata_a,
  output logic        adel,
  output logic        ades,
  output logic        bus_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  mem_state_e  state;
  logic        access;
  logic        aligned;
  logic        timeout_hit;
  logic [3:0]  be;
  logic [31:0] lane_wdata;

  mem_lane_gen u_lane_gen (
    .op         (op),
    .addr_lo    (addr[1:0]),
    .wdata      (wdata),
    .be         (be),
    .lane_wdata (lane_wdata),
    .aligned    (aligned)
  );

  assign access = (mem_read | mem_write) & (op != OP_NONE);

  // The accepting IDLE cycle must stall before the bus registers load
  assign stall     = ((state == ST_IDLE) & access & aligned) | (state == ST_REQ);
  assign adel      = (state == ST_IDLE) & access & ~aligned & ~mem_write;
  assign ades      = (state == ST_IDLE) & access & ~aligned & mem_write;
  assign bus_fault = (state == ST_FAULT);

`ifdef MEM_BUS_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // Count REQ cycles without ack; cleared whenever a transfer is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((state == ST_IDLE) && access && aligned) begin
      cnt <= '0;
    end else if ((state == ST_REQ) && !bus_ack) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  // Without the timeout REQ waits for bus_ack indefinitely
  logic [31:0] unused_cfg;
  assign unused_cfg  = 32'(TIMEOUT) ^ 32'(CNT_W);
  assign timeout_hit = 1'b0;
`endif

  // Transfer sequencing with registered bus outputs and captured read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
      rdata_a   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access && aligned) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be;
            bus_wdata <= lane_wdata;
            rdata_a   <= addr[1:0];
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (bus_err) begin
              state <= ST_FAULT;
            end else begin
              state <= ST_DONE;
              if (!bus_we) begin
                rdata <= bus_rdata;
              end
            end
          end else if (timeout_hit) begin
            bus_req <= 1'b0;
            state   <= ST_FAULT;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_FAULT: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: stimulus pushes expected bus requests,
// completions and address exceptions; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  op = OP_NONE;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic [31:0] rdata;
  logic [1:0]  rdata_a;
  logic        adel;
  logic        ades;
  logic        bus_fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct packed {
    logic        fault;
    logic [31:0] rdata;
    logic [1:0]  rdata_a;
    logic [31:0] stall_cycles;
  } cpl_exp_t;

  typedef struct packed {
    logic adel;
    logic ades;
  } exc_exp_t;

  bus_exp_t bus_q[$];
  cpl_exp_t cpl_q[$];
  exc_exp_t exc_q[$];

  mem_bus_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rdata     (rdata),
    .rdata_a   (rdata_a),
    .adel      (adel),
    .ades      (ades),
    .bus_fault (bus_fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations when the DUT starts, finishes or rejects an access
  initial begin
    logic     prev_req;
    int       run;
    bus_exp_t b;
    cpl_exp_t c;
    exc_exp_t e;
    prev_req = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
        run = 0;
      end else begin
        if (stall) run++;
        if (bus_req && !prev_req) begin
          if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: got addr 0x%08h, no request expected", bus_addr);
          end else begin
            b = bus_q.pop_front();
            check("bus_addr", bus_addr, b.addr);
            check("bus_we", 32'(bus_we), 32'(b.we));
            check("bus_be", 32'(bus_be), 32'(b.be));
            check("bus_wdata", bus_wdata, b.wdata);
          end
        end
        if (!bus_req && prev_req) begin
          if (cpl_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cpl: got a completion, none expected");
          end else begin
            c = cpl_q.pop_front();
            check("cpl_stall", 32'(stall), 32'(0));
            check("cpl_bus_fault", 32'(bus_fault), 32'(c.fault));
            check("cpl_rdata", rdata, c.rdata);
            check("cpl_rdata_a", 32'(rdata_a), 32'(c.rdata_a));
            check("cpl_stall_cycles", 32'(run), c.stall_cycles);
          end
          run = 0;
        end
        if (adel || ades) begin
          if (exc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_exc: got adel=%0b ades=%0b, none expected", adel, ades);
          end else begin
            e = exc_q.pop_front();
            check("exc_adel", 32'(adel), 32'(e.adel));
            check("exc_ades", 32'(ades), 32'(e.ades));
            check("exc_stall", 32'(stall), 32'(0));
            check("exc_bus_req", 32'(bus_req), 32'(0));
          end
        end
        prev_req = bus_req;
      end
    end
  end

  task automatic clear_inputs();
    mem_read = 1'b0;
    mem_write = 1'b0;
    op = OP_NONE;
    addr = '0;
    wdata = '0;
  endtask

  // One bus transfer; ack after 'waits' REQ cycles, or none (ack=0) for timeout.
  // complete=0 leaves the transfer hanging in REQ for the caller.
  task automatic run_access(
    input logic rd, input logic wr, input logic [1:0] op_i,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp_wd,
    input int waits, input logic ack, input logic err, input logic [31:0] brd,
    input logic exp_fault, input logic [31:0] exp_rdata, input logic [1:0] exp_ra,
    input logic complete);
    bus_q.push_back('{exp_addr, wr, exp_be, exp_wd});
    if (complete) cpl_q.push_back('{exp_fault, exp_rdata, exp_ra, 32'(waits + 2)});
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; op = op_i; addr = a; wdata = wd;
    @(posedge clk); #1;
    repeat (waits) begin @(posedge clk); #1; end
    if (complete) begin
      if (ack) begin
        bus_ack = 1'b1; bus_err = err; bus_rdata = brd;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
      clear_inputs();
      @(posedge clk); #1;
    end
  endtask

  task automatic run_exc(input logic rd, input logic wr, input logic [1:0] op_i,
                         input logic [31:0] a, input logic ea, input logic es);
    exc_q.push_back('{ea, es});
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; op = op_i; addr = a; wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    #1;
    check("rst_bus_req", 32'(bus_req), 32'(0));
    check("rst_bus_we", 32'(bus_we), 32'(0));
    check("rst_bus_be", 32'(bus_be), 32'(0));
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rdata_a", 32'(rdata_a), 32'(0));
    check("rst_flags", {29'd0, adel, ades, bus_fault}, 32'h0);
    check("rst_stall", 32'(stall), 32'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset while hanging in REQ abandons the transfer
    run_access(1'b1, 1'b0, OP_WORD, 32'h300, 32'h0, 32'h300, 4'b1111, 32'h0,
               2, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("async_rst_bus_req", 32'(bus_req), 32'(0));
    clear_inputs();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_stall", 32'(stall), 32'(0));
    check("post_rst_bus_req", 32'(bus_req), 32'(0));

    // sw 0x100, immediate ack
    run_access(1'b0, 1'b1, OP_WORD, 32'h100, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF,
               0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b1);
    // sb 0x103
    run_access(1'b0, 1'b1, OP_BYTE, 32'h103, 32'h000000A5, 32'h100, 4'b1000, 32'hA5A5A5A5,
               0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2'b11, 1'b1);
    // sh 0x102
    run_access(1'b0, 1'b1, OP_HALF, 32'h102, 32'h00001234, 32'h100, 4'b1100, 32'h12341234,
               0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2'b10, 1'b1);
    // lw 0x204, three wait cycles
    run_access(1'b1, 1'b0, OP_WORD, 32'h204, 32'h0, 32'h204, 4'b1111, 32'h0,
               3, 1'b1, 1'b0, 32'h89ABCDEF, 1'b0, 32'h89ABCDEF, 2'b00, 1'b1);
    // lb 0x207, one wait cycle
    run_access(1'b1, 1'b0, OP_BYTE, 32'h207, 32'h0, 32'h204, 4'b1000, 32'h0,
               1, 1'b1, 1'b0, 32'h11223344, 1'b0, 32'h11223344, 2'b11, 1'b1);

    // Misaligned accesses
    run_exc(1'b1, 1'b0, OP_HALF, 32'h201, 1'b1, 1'b0);
    run_exc(1'b0, 1'b1, OP_WORD, 32'h202, 1'b0, 1'b1);
    run_exc(1'b1, 1'b0, OP_WORD, 32'h206, 1'b1, 1'b0);
    run_exc(1'b0, 1'b1, OP_HALF, 32'h203, 1'b0, 1'b1);

    // op=11 is not an access
    @(posedge clk); #1;
    mem_read = 1'b1; op = OP_NONE; addr = 32'h501;
    @(negedge clk);
    check("opnone_stall", 32'(stall), 32'(0));
    check("opnone_adel", 32'(adel), 32'(0));
    @(posedge clk); #1;
    check("opnone_bus_req", 32'(bus_req), 32'(0));
    clear_inputs();

    // Bus error: fault pulse, rdata kept
    run_access(1'b1, 1'b0, OP_WORD, 32'h300, 32'h0, 32'h300, 4'b1111, 32'h0,
               1, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1, 32'h11223344, 2'b00, 1'b1);

    // Read and write together: store wins, rdata kept
    run_access(1'b1, 1'b1, OP_BYTE, 32'h301, 32'h0000005A, 32'h300, 4'b0010, 32'h5A5A5A5A,
               0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h11223344, 2'b01, 1'b1);

`ifdef MEM_BUS_TIMEOUT_EN
    // No ack: fault after four REQ cycles
    run_access(1'b1, 1'b0, OP_WORD, 32'h400, 32'h0, 32'h400, 4'b1111, 32'h0,
               3, 1'b0, 1'b0, 32'h0, 1'b1, 32'h11223344, 2'b00, 1'b1);
`endif

    repeat (3) @(posedge clk);
    check("bus_q_drained", 32'(bus_q.size()), 32'(0));
    check("cpl_q_drained", 32'(cpl_q.size()), 32'(0));
    check("exc_q_drained", 32'(exc_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
